// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
//   Pipelined logical / arithmetic / rotate barrel shifter. Stage i shifts by
//   2^i when amount bit i is set. All stages advance together on a single
//   global enable. A valid/ready handshake on each side and a user tag ride
//   along with the data.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   flush            synchronous clear of all stage valid bits
//   in_valid/ready   input handshake (in_ready = adv & ~flush)
//   in_data          operand
//   in_amount        shift amount
//   in_dir           0 = right, 1 = left
//   in_mode          00 logical, 01 arithmetic, 1x rotate
//   in_tag           sideband carried unchanged
//   out_valid/ready  output handshake
//   out_data         shifted result
//   out_tag          tag of the result
//   out_zero         out_data == 0, gated by out_valid
module barrel_shifter_pipe #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SHIFT_WIDTH = 3,
  parameter int unsigned TAG_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SHIFT_WIDTH-1:0] in_amount,
  input  logic                   in_dir,
  input  logic [1:0]             in_mode,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic                   out_zero
);

  // Stage registers
  logic [SHIFT_WIDTH-1:0][WIDTH-1:0]       data_q;
  logic [SHIFT_WIDTH-1:0][SHIFT_WIDTH-1:0] amt_q;
  logic [SHIFT_WIDTH-1:0]                  dir_q;
  logic [SHIFT_WIDTH-1:0][1:0]             mode_q;
  logic [SHIFT_WIDTH-1:0][TAG_WIDTH-1:0]   tag_q;
  logic [SHIFT_WIDTH-1:0]                  valid_q;

  // Stage inputs (previous stage or the input port) and next-state values
  logic [SHIFT_WIDTH-1:0][WIDTH-1:0]       st_data;
  logic [SHIFT_WIDTH-1:0][SHIFT_WIDTH-1:0] st_amt;
  logic [SHIFT_WIDTH-1:0]                  st_dir;
  logic [SHIFT_WIDTH-1:0][1:0]             st_mode;
  logic [SHIFT_WIDTH-1:0][TAG_WIDTH-1:0]   st_tag;
  logic [SHIFT_WIDTH-1:0]                  st_valid;
  logic [SHIFT_WIDTH-1:0][WIDTH-1:0]       nxt_data;
  logic [SHIFT_WIDTH-1:0][SHIFT_WIDTH-1:0] nxt_amt;

  logic adv;
  logic accept;

  // Single fixed-distance step. Rotation by k uses k mod WIDTH so that any
  // WIDTH (including non powers of two) and any k >= WIDTH behave correctly.
  function automatic logic [WIDTH-1:0] step_shift(
    input logic [WIDTH-1:0] d,
    input logic             dir,
    input logic [1:0]       mode,
    input int unsigned      k
  );
    logic [2*WIDTH-1:0] dd;
    logic [2*WIDTH-1:0] rl;
    logic [2*WIDTH-1:0] rr;
    int unsigned        r;
    r  = k % WIDTH;
    dd = {d, d};
    rl = dd << r;
    rr = dd >> r;
    if (mode[1])
      return dir ? rl[2*WIDTH-1:WIDTH] : rr[WIDTH-1:0];
    if (k >= WIDTH)
      return (!dir && mode[0]) ? {WIDTH{d[WIDTH-1]}} : '0;
    if (dir)
      return d << k;
    if (mode[0])
      return $signed(d) >>> k;
    return d >> k;
  endfunction

  assign out_valid = valid_q[SHIFT_WIDTH-1];
  assign out_data  = data_q[SHIFT_WIDTH-1];
  assign out_tag   = tag_q[SHIFT_WIDTH-1];
  assign out_zero  = out_valid & ~|out_data;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv & ~flush;
  assign accept   = in_valid & in_ready;

  // Each stage consumes bit 0 of its remaining amount and passes the rest
  // down shifted by one, so every stage looks at the same bit position.
  for (genvar i = 0; i < SHIFT_WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign st_data[i]  = in_data;
      assign st_amt[i]   = in_amount;
      assign st_dir[i]   = in_dir;
      assign st_mode[i]  = in_mode;
      assign st_tag[i]   = in_tag;
      assign st_valid[i] = accept;
    end else begin : g_next
      assign st_data[i]  = data_q[i-1];
      assign st_amt[i]   = amt_q[i-1];
      assign st_dir[i]   = dir_q[i-1];
      assign st_mode[i]  = mode_q[i-1];
      assign st_tag[i]   = tag_q[i-1];
      assign st_valid[i] = valid_q[i-1];
    end
    assign nxt_data[i] = st_amt[i][0]
                       ? step_shift(st_data[i], st_dir[i], st_mode[i], 32'd1 << i)
                       : st_data[i];
    assign nxt_amt[i]  = st_amt[i] >> 1;
  end

  // The last stage's control fields have no consumer.
  logic unused_tail;
  assign unused_tail = ^{amt_q[SHIFT_WIDTH-1], dir_q[SHIFT_WIDTH-1],
                         mode_q[SHIFT_WIDTH-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      amt_q   <= '0;
      dir_q   <= '0;
      mode_q  <= '0;
      tag_q   <= '0;
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (adv) begin
      data_q  <= nxt_data;
      amt_q   <= nxt_amt;
      dir_q   <= st_dir;
      mode_q  <= st_mode;
      tag_q   <= st_tag;
      valid_q <= st_valid;
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amount;
  logic       in_dir;
  logic [1:0] in_mode;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_tag;
  logic       out_zero;

  logic       in_valid6;
  logic       in_ready6;
  logic [5:0] in_data6;
  logic [2:0] in_amount6;
  logic       in_dir6;
  logic [1:0] in_mode6;
  logic [3:0] in_tag6;
  logic       out_valid6;
  logic       out_ready6;
  logic [5:0] out_data6;
  logic [3:0] out_tag6;
  logic       out_zero6;

  barrel_shifter_pipe #(.WIDTH(8), .SHIFT_WIDTH(3), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amount(in_amount), .in_dir(in_dir), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_zero(out_zero)
  );

  barrel_shifter_pipe #(.WIDTH(6), .SHIFT_WIDTH(3), .TAG_WIDTH(4)) dut6 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
    .in_amount(in_amount6), .in_dir(in_dir6), .in_mode(in_mode6), .in_tag(in_tag6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
    .out_tag(out_tag6), .out_zero(out_zero6)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t sb[$];
  int   done_cyc[$];
  exp_t pend;
  bit   accepted;
  bit   rnd_ready  = 1'b0;
  bit   stall_prev = 1'b0;
  logic [7:0] held_data;
  logic [3:0] held_tag;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Independent reference: rotates and arithmetic shifts one bit at a time.
  function automatic logic [7:0] ref_model(input logic [7:0] d, input int unsigned a,
                                           input logic dir, input logic [1:0] m);
    logic [7:0] r;
    r = d;
    if (m[1]) begin
      for (int unsigned j = 0; j < a % 8; j++)
        r = dir ? {r[6:0], r[7]} : {r[0], r[7:1]};
    end else if (dir) begin
      r = (a >= 8) ? 8'h00 : d << a;
    end else if (m[0]) begin
      for (int unsigned j = 0; j < a && j < 8; j++)
        r = {r[7], r[7:1]};
    end else begin
      r = (a >= 8) ? 8'h00 : d >> a;
    end
    return r;
  endfunction

  // One clock: called at a negedge with inputs driven; samples handshakes
  // just before the rising edge, then returns at the next negedge.
  task automatic tick();
    exp_t e;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
    if (stall_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, held_data);
      check("hold_tag", out_tag, held_tag);
    end
    if (flush) begin
      check("in_ready_during_flush", in_ready, 0);
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_tag", out_tag, e.tag);
          check("out_zero", out_zero, (e.data == 8'h00));
          done_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(pend);
        accepted = 1'b1;
      end
    end
    stall_prev = out_valid && !out_ready && !flush;
    held_data  = out_data;
    held_tag   = out_tag;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send_op(input logic [7:0] d, input logic [2:0] a, input logic dir,
                         input logic [1:0] m, input logic [3:0] tag, input logic [7:0] exp);
    in_data   = d;
    in_amount = a;
    in_dir    = dir;
    in_mode   = m;
    in_tag    = tag;
    pend      = '{data: exp, tag: tag};
    in_valid  = 1'b1;
    accepted  = 1'b0;
    for (int k = 0; k < 100 && !accepted; k++) tick();
    check("accept_within_budget", accepted, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) tick();
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [7:0] d;
    logic [2:0] a;
    logic       dr;
    logic [1:0] md;
    int         base;
    bit         seen6;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_data = '0; in_amount = '0; in_dir = 1'b0; in_mode = '0; in_tag = '0;
    in_valid6 = 1'b0; in_data6 = '0; in_amount6 = '0; in_dir6 = 1'b0; in_mode6 = '0;
    in_tag6 = '0; out_ready6 = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_zero", out_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Rotate left 0xB4 by 3 with latency check
    send_op(8'hB4, 3'd3, 1'b1, 2'b10, 4'h5, 8'hA5);
    check("rot_lat_edge0", out_valid, 0);
    tick();
    check("rot_lat_edge1", out_valid, 0);
    tick();
    check("rot_lat_edge2", out_valid, 1);
    drain(10);

    // Logical vs arithmetic right, back to back
    done_cyc.delete();
    send_op(8'hB4, 3'd2, 1'b0, 2'b00, 4'h1, 8'h2D);
    send_op(8'hB4, 3'd2, 1'b0, 2'b01, 4'h2, 8'hED);
    drain(10);
    check("b2b_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) check("b2b_consecutive", done_cyc[1] - done_cyc[0], 1);

    // Logical shifts to the edge and to zero
    send_op(8'hB4, 3'd5, 1'b1, 2'b00, 4'h3, 8'h80);
    send_op(8'h01, 3'd7, 1'b0, 2'b00, 4'h4, 8'h00);
    drain(10);

    // Rotate-reserved alias and amount zero
    send_op(8'hB4, 3'd1, 1'b0, 2'b11, 4'h6, 8'h5A);
    send_op(8'h9C, 3'd0, 1'b0, 2'b01, 4'h7, 8'h9C);
    drain(10);

    // Backpressure with random operands and random out_ready
    base = done_cyc.size();
    rnd_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      d  = 8'($urandom);
      a  = 3'($urandom_range(0, 7));
      dr = 1'($urandom_range(0, 1));
      md = 2'($urandom_range(0, 3));
      send_op(d, a, dr, md, 4'(t), ref_model(d, a, dr, md));
    end
    drain(200);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    check("bp_completions", done_cyc.size() - base, 10);

    // Flush with three operands in flight and a stalled output
    out_ready = 1'b0;
    send_op(8'h11, 3'd1, 1'b1, 2'b00, 4'h8, 8'h22);
    send_op(8'h22, 3'd1, 1'b1, 2'b00, 4'h9, 8'h44);
    send_op(8'h33, 3'd1, 1'b1, 2'b00, 4'hA, 8'h66);
    check("pre_flush_valid", out_valid, 1);
    flush = 1'b1; in_valid = 1'b1; in_tag = 4'hF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("post_flush_valid", out_valid, 0);
    out_ready = 1'b1;
    send_op(8'h0F, 3'd4, 1'b1, 2'b00, 4'hB, 8'hF0);
    check("flush_lat_edge0", out_valid, 0);
    tick();
    check("flush_lat_edge1", out_valid, 0);
    tick();
    check("flush_lat_edge2", out_valid, 1);
    drain(10);

    // Asynchronous reset between edges with a full pipeline
    out_ready = 1'b0;
    send_op(8'h81, 3'd1, 1'b0, 2'b01, 4'hC, 8'hC0);
    send_op(8'h82, 3'd2, 1'b0, 2'b01, 4'hD, 8'hE0);
    send_op(8'h83, 3'd3, 1'b0, 2'b01, 4'hE, 8'hF0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_tag", out_tag, 0);
    check("async_rst_zero", out_zero, 0);
    sb.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("post_rst_no_stale", out_valid, 0);
    end

    // WIDTH = 6: rotate right by 7 equals rotate right by 1
    in_valid6 = 1'b1; in_data6 = 6'h21; in_amount6 = 3'd7; in_dir6 = 1'b0;
    in_mode6 = 2'b10; in_tag6 = 4'hA;
    #1;
    check("w6_in_ready", in_ready6, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid6 = 1'b0;
    seen6 = 1'b0;
    for (int k = 0; k < 10 && !seen6; k++) begin
      if (out_valid6) seen6 = 1'b1;
      else @(negedge clk);
    end
    check("w6_out_valid", out_valid6, 1);
    check("w6_out_data", out_data6, 6'h30);
    check("w6_out_tag", out_tag6, 4'hA);
    check("w6_out_zero", out_zero6, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Pipelined, parametrised successor to the team's combinational barrel shifter.
- Supports logical shift, arithmetic shift and rotate, in either direction.
- Has one register stage per shift-amount bit and a valid/ready handshake on input and output, so it sits directly in streaming datapaths.
- Carries a user tag alongside each operand, and supports a synchronous flush.

Parameters:
- WIDTH, 8: data width in bits; must be >= 2.
- SHIFT_WIDTH, 3: shift-amount width and pipeline depth; must be >= clog2(WIDTH).
- TAG_WIDTH, 4: width of the sideband tag carried with each operand.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline clear; active-high.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  WIDTH  operand.
- in_amount  input  SHIFT_WIDTH  shift amount.
- in_dir  input  1  0 = right, 1 = left (same encoding as the combinational shifter).
- in_mode  input  2  00 = logical, 01 = arithmetic, 10 = rotate, 11 = rotate (reserved alias).
- in_tag  input  TAG_WIDTH  sideband, passed through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_WIDTH  tag of the result.
- out_zero  output  1  out_data == 0; qualified by out_valid.

Behaviour:
- Pipeline structure:
  - Stages S0..S(SHIFT_WIDTH-1) are registered.
  - Stage i applies a shift or rotate by 2^i when the operand's amount bit i is 1; otherwise it passes the data through.
  - Each stage register holds data, the remaining amount bits, dir, mode, tag and a valid bit.
  - The output ports are driven directly from the last stage.
- Global enable: adv = out_ready | ~out_valid.
  - When adv = 1, all stages shift forward one position together.
  - When adv = 0, every stage holds its contents.
  - Bubbles are not collapsed.
- Input handshake:
  - in_ready = adv & ~flush (combinational).
  - An operand is accepted on a rising edge when in_valid & in_ready.
  - When no operand is accepted but adv = 1, S0 loads valid = 0.
- Output handshake:
  - A result completes on a rising edge when out_valid & out_ready.
  - out_data, out_tag and out_valid hold stable while out_valid & ~out_ready.
- Latency and throughput:
  - With no stall, an operand accepted on edge N is presented on the outputs after edge N+SHIFT_WIDTH-1.
  - Throughput is 1 operand per cycle.
- Per-stage arithmetic (k = 2^i):
  - Logical left: d << k, zero fill.
  - Logical right: d >> k, zero fill.
  - Arithmetic right: fill with d[WIDTH-1].
  - Arithmetic left: identical to logical left.
  - Rotate: bits leaving one end re-enter the other end, for any WIDTH.
  - When k >= WIDTH:
    - Logical stages output 0.
    - Arithmetic-right stages output all copies of the sign bit.
    - Rotate stages rotate by k mod WIDTH.
  - Consequences at the output:
    - Total logical shifts >= WIDTH give 0.
    - Arithmetic right saturates to all sign bits.
    - Rotate equals rotate by amount mod WIDTH.
    - Amount 0 passes data through unchanged in every mode.
- Reset (rst = 1, asynchronous):
  - Clears all stage valid bits and zeroes all stage data and tags.
  - out_valid = 0, out_data = 0, out_tag = 0, out_zero = 0 (out_zero is gated by valid).
  - in_ready = 1 once rst is released and flush = 0.
  - Reset asserted mid-operation discards all in-flight operands; none reappear.
- Flush:
  - On an edge with flush = 1, all stage valid bits clear; data need not change.
  - No input is accepted on that edge.
  - Flush overrides simultaneous in_valid and any stall.
- Simultaneous accept and complete on the same edge is legal: the pipeline shifts and the new operand enters S0.
- No operand is ever dropped or duplicated under arbitrary out_ready patterns.

Test Plan:
- Rotate left: WIDTH=8, in_data=0xB4, amount=3, dir=1, mode=10, tag=0x5, out_ready=1 -> after 3 edges out_data=0xA5, out_tag=0x5, out_zero=0.
- Shift right, logical vs arithmetic: 0xB4, amount=2, dir=0 -> mode=00 gives 0x2D; mode=01 gives 0xED. Issue both back to back -> results on consecutive cycles.
- Logical left to zero: 0xB4, amount=5, dir=1, mode=00 -> 0x80. Then 0x01, amount=7, dir=0, mode=00 -> 0x00 with out_zero=1.
- Backpressure: stream tags 0..9 with random amounts while out_ready toggles pseudo-randomly -> all 10 results appear in order, each matching the reference model, out_data stable while stalled, no loss or duplication.
- Flush: 3 operands in flight, assert flush for 1 cycle with in_valid=1 -> out_valid=0 on the next cycle, in_ready=0 during flush, and an operand sent afterwards emerges after 3 edges.
- Reset: assert rst asynchronously between edges with the pipeline full -> all outputs 0 immediately. After release, in_ready=1 and no stale results appear.
- Non-power-of-two width: WIDTH=6, SHIFT_WIDTH=3, 0x21 rotate right by 7 -> same result as rotate by 1 = 0x30.
